// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX payload, waits for data-SRAM responses in order,
// buffers read data under WB back-pressure and drops responses orphaned by a flush.
module mem_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         es_to_ms_valid,
    input  logic [118:0] es_to_ms_bus,
    output logic         ms_allowin,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [149:0] ms_to_ws_bus,
    input  logic         data_data_ok,
    input  logic [31:0]  data_rdata,
    input  logic         flush,
    output logic [4:0]   MS_dest,
    output logic [31:0]  MS_result,
    output logic         MS_load_stall
);

    localparam logic [DISCARD_W-1:0] CNT_MAX = '1;
    localparam logic [DISCARD_W-1:0] CNT_ONE = DISCARD_W'(1);

    logic                 ms_valid;
    logic [118:0]         bus_r;
    logic                 got_ok;
    logic [31:0]          rdata_buf;
    logic [DISCARD_W-1:0] discard_cnt;

    logic        req_sent;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic [31:0] result;

    logic        waiting;
    logic        resp_use;
    logic        ms_ready_go;
    logic        orphan_ok;
    logic        cnt_inc;
    logic [31:0] rdata_sel;

    assign req_sent     = bus_r[118];
    assign res_from_mem = bus_r[117];
    assign dest         = bus_r[68:64];
    assign result       = bus_r[63:32];

    // A strobe is only ours once every orphaned response ahead of it has drained.
    assign waiting     = ms_valid & req_sent & ~got_ok;
    assign orphan_ok   = data_data_ok & (discard_cnt != '0);
    assign resp_use    = data_data_ok & (discard_cnt == '0) & waiting;
    assign ms_ready_go = ~waiting | resp_use;
    assign cnt_inc     = flush & waiting & ~resp_use;

    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;

    assign rdata_sel = got_ok   ? rdata_buf  :
                       resp_use ? data_rdata : 32'h0;

    assign ms_to_ws_bus  = {bus_r[117:73], rdata_sel, bus_r[72:0]};
    assign MS_dest       = dest & {5{ms_valid}};
    assign MS_result     = res_from_mem ? rdata_sel : result;
    assign MS_load_stall = ms_valid & res_from_mem & ~ms_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid  <= 1'b0;
            bus_r     <= '0;
            got_ok    <= 1'b0;
            rdata_buf <= 32'h0;
        end else if (flush) begin
            ms_valid <= 1'b0;
            got_ok   <= 1'b0;
        end else if (ms_allowin) begin
            if (es_to_ms_valid) begin
                ms_valid <= 1'b1;
                bus_r    <= es_to_ms_bus;
                got_ok   <= 1'b0;
            end else begin
                ms_valid <= 1'b0;
            end
        end else if (resp_use) begin
            // Stalled by WB: keep the data until the payload can leave.
            rdata_buf <= data_rdata;
            got_ok    <= 1'b1;
        end
    end

    // A coincident flush and orphan strobe cancel out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else if (cnt_inc && !orphan_ok) begin
            if (discard_cnt != CNT_MAX) begin
                discard_cnt <= discard_cnt + CNT_ONE;
            end
        end else if (orphan_ok && !cnt_inc) begin
            discard_cnt <= discard_cnt - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random traffic,
// compared against a transaction-level model that tracks outstanding responses in a queue.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         es_to_ms_valid;
    logic [118:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [149:0] ms_to_ws_bus;
    logic         data_data_ok;
    logic [31:0]  data_rdata;
    logic         flush;
    logic [4:0]   MS_dest;
    logic [31:0]  MS_result;
    logic         MS_load_stall;

    always #5 clk = ~clk;

    mem_stage #(.DISCARD_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
        .MS_dest(MS_dest), .MS_result(MS_result), .MS_load_stall(MS_load_stall)
    );

    int tests = 0;
    int fails = 0;

    // Model: the instruction held in MEM plus one queue entry per outstanding request (1 = orphaned).
    logic         m_valid;
    logic [118:0] m_pl;
    logic         m_has;
    logic [31:0]  m_data;
    bit           q[$];

    logic         p_wait, p_deliver, p_ready, p_allowin, p_out_valid, p_accept;
    logic [31:0]  p_rd;
    logic [149:0] p_bus;

    logic         s_valid, s_stall, s_allowin, s_ms_valid;
    logic [149:0] s_bus;
    logic [1:0]   s_cnt;

    task automatic checkOutput(input string tag, input logic [149:0] got, input logic [149:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dead_count();
        int n = 0;
        foreach (q[i]) if (q[i]) n++;
        return n;
    endfunction

    function automatic logic [118:0] mk(input logic req, input logic rfm, input logic ex,
                                        input logic we, input logic [4:0] dst,
                                        input logic [31:0] res, input logic [31:0] pc);
        return {req, rfm, 12'h0, 32'h0, 2'b00, ex, we, dst, res, pc};
    endfunction

    function automatic logic [118:0] rand_payload();
        logic [118:0] p;
        p = 119'({$urandom, $urandom, $urandom, $urandom});
        p[70]  = ($urandom_range(0, 7) == 0);
        p[118] = p[70] ? 1'b0 : 1'($urandom_range(0, 1));
        p[117] = p[118] ? 1'($urandom_range(0, 1)) : 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pl    = '0;
        m_has   = 1'b0;
        m_data  = 32'h0;
        q.delete();
    endtask

    task automatic check_reset(input string tag);
        checkOutput({tag, "_allowin"}, 150'(ms_allowin), 150'(1'b1));
        checkOutput({tag, "_valid"}, 150'(ms_to_ws_valid), 150'(1'b0));
        checkOutput({tag, "_bus"}, ms_to_ws_bus, 150'(0));
        checkOutput({tag, "_dest"}, 150'(MS_dest), 150'(0));
        checkOutput({tag, "_result"}, 150'(MS_result), 150'(0));
        checkOutput({tag, "_stall"}, 150'(MS_load_stall), 150'(1'b0));
        checkOutput({tag, "_cnt"}, 150'(dut.discard_cnt), 150'(0));
    endtask

    // One cycle: drive after the falling edge, compare mid-cycle, advance the model at the rising edge.
    task automatic applyStimulus(input logic ev, input logic [118:0] eb, input logic wa,
                                 input logic dok, input logic [31:0] rd, input logic fl);
        @(negedge clk);
        es_to_ms_valid = ev;
        es_to_ms_bus   = eb;
        ws_allowin     = wa;
        data_data_ok   = dok;
        data_rdata     = rd;
        flush          = fl;
        #1;
        p_wait      = m_valid & m_pl[118] & ~m_has;
        p_deliver   = dok && q.size() > 0 && !q[0];
        p_ready     = ~p_wait | p_deliver;
        p_allowin   = ~m_valid | (p_ready & wa);
        p_out_valid = m_valid & p_ready & ~fl;
        p_accept    = ev & p_allowin & ~fl;
        p_rd        = m_has ? m_data : (p_deliver ? rd : 32'h0);
        p_bus       = {m_pl[117], m_pl[116:105], m_pl[104:73], p_rd, m_pl[72:71],
                       m_pl[70], m_pl[69], m_pl[68:64], m_pl[63:32], m_pl[31:0]};
        s_valid    = ms_to_ws_valid;
        s_stall    = MS_load_stall;
        s_allowin  = ms_allowin;
        s_bus      = ms_to_ws_bus;
        s_cnt      = dut.discard_cnt;
        s_ms_valid = dut.ms_valid;
        checkOutput("allowin", 150'(ms_allowin), 150'(p_allowin));
        checkOutput("out_valid", 150'(ms_to_ws_valid), 150'(p_out_valid));
        checkOutput("bus", ms_to_ws_bus, p_bus);
        checkOutput("ms_dest", 150'(MS_dest), 150'(m_valid ? m_pl[68:64] : 5'd0));
        checkOutput("ms_result", 150'(MS_result), 150'(m_pl[117] ? p_rd : m_pl[63:32]));
        checkOutput("load_stall", 150'(MS_load_stall), 150'(m_valid & m_pl[117] & ~p_ready));
        checkOutput("discard_cnt", 150'(dut.discard_cnt), 150'(dead_count()));
        checkOutput("cnt_not_saturated", 150'(dut.discard_cnt != 2'b11), 150'(1'b1));
        @(posedge clk);
        if (dok && q.size() > 0) void'(q.pop_front());
        if (fl) begin
            if (p_wait && !p_deliver && q.size() > 0) q[q.size() - 1] = 1'b1;
            m_valid = 1'b0;
            m_has   = 1'b0;
        end else if (p_allowin) begin
            if (ev) begin
                m_pl    = eb;
                m_valid = 1'b1;
                m_has   = 1'b0;
                if (eb[118]) q.push_back(1'b0);
            end else begin
                m_valid = 1'b0;
            end
        end else if (p_deliver) begin
            m_has  = 1'b1;
            m_data = rd;
        end
    endtask

    initial begin
        logic [118:0] pend;
        bit           has_pend;
        bit           fl, dok, wa;
        int           xfer;

        resetn = 1'b1;
        es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b0;
        data_data_ok = 1'b0; data_rdata = 32'h0; flush = 1'b0;
        model_reset();
        #1 resetn = 1'b0;
        #2 check_reset("reset");
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);

        // ALU pass-through
        applyStimulus(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h100), 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("alu_valid", 150'(s_valid), 150'(1'b1));
        checkOutput("alu_result", 150'(s_bus[63:32]), 150'(32'h1234));
        checkOutput("alu_dest", 150'(s_bus[68:64]), 150'(5'd5));
        checkOutput("alu_rdata", 150'(s_bus[104:73]), 150'(0));

        // Load answered after three cycles with WB ready
        applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h200), 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("zl_stall", 150'(s_stall), 150'(1'b1));
            checkOutput("zl_allowin", 150'(s_allowin), 150'(1'b0));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        checkOutput("zl_valid", 150'(s_valid), 150'(1'b1));
        checkOutput("zl_rdata", 150'(s_bus[104:73]), 150'(32'hDEADBEEF));

        // Load answered while WB is stalled
        applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h300), 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        xfer = 0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
        checkOutput("buf_valid", 150'(s_valid), 150'(1'b1));
        checkOutput("buf_rdata", 150'(s_bus[104:73]), 150'(32'hCAFEF00D));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("buf_hold_valid", 150'(s_valid), 150'(1'b1));
            checkOutput("buf_hold_rdata", 150'(s_bus[104:73]), 150'(32'hCAFEF00D));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("buf_release_rdata", 150'(s_bus[104:73]), 150'(32'hCAFEF00D));
        if (s_valid) xfer++;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        if (s_valid) xfer++;
        checkOutput("buf_xfer_once", 150'(xfer), 150'(1));

        // Flush while a load waits, then load B
        applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h400), 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h0, 32'h404), 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("fl_cnt_one", 150'(s_cnt), 150'(1));
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h11111111, 1'b0);
        checkOutput("fl_drop_valid", 150'(s_valid), 150'(1'b0));
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h22222222, 1'b0);
        checkOutput("fl_cnt_zero", 150'(s_cnt), 150'(0));
        checkOutput("fl_b_valid", 150'(s_valid), 150'(1'b1));
        checkOutput("fl_b_rdata", 150'(s_bus[104:73]), 150'(32'h22222222));

        // Exception payload flushed
        applyStimulus(1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h55, 32'h500), 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("ex_flush_valid", 150'(s_valid), 150'(1'b0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("ex_ms_valid", 150'(s_ms_valid), 150'(1'b0));

        // Asynchronous reset during a wait with an orphan outstanding
        applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0, 32'h600), 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 32'h604), 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("ar_pre_stall", 150'(s_stall), 150'(1'b1));
        @(negedge clk);
        es_to_ms_valid = 1'b0; ws_allowin = 1'b1; data_data_ok = 1'b0; flush = 1'b0;
        resetn = 1'b0;
        #1 check_reset("async_reset");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic
        has_pend = 1'b0;
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            if (!has_pend && $urandom_range(0, 2) != 0) begin
                pend = rand_payload();
                has_pend = 1'b1;
            end
            fl  = ($urandom_range(0, 15) == 0) && (dead_count() < 2);
            dok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            wa  = ($urandom_range(0, 3) != 0);
            applyStimulus(has_pend, pend, wa, dok, $urandom, fl);
            if (p_accept || fl) has_pend = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
